// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding, default timing constants and helpers for pll_reset_sequencer
package pll_seq_pkg;
    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAIL      = 3'd4;
    typedef enum logic [2:0] {
        S_PLL_RST   = ST_PLL_RST,
        S_WAIT_LOCK = ST_WAIT_LOCK,
        S_STABLE    = ST_STABLE,
        S_RUN       = ST_RUN,
        S_FAIL      = ST_FAIL
    } state_t;
    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 1200;
    localparam int DEF_STABLE_CYCLES = 120;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int LOSS_CNT_W        = 8;
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: 2-flop synchronizer for an asynchronous status input
//   i_clk   destination clock
//   i_rst_n asynchronous active-low reset, clears both flops
//   i_async asynchronous input
//   o_sync  synchronized output, two i_clk edges of latency
module pll_lock_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);
    logic r_meta, r_sync;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) {r_sync, r_meta} <= 2'b00;
        else          {r_sync, r_meta} <= {r_meta, i_async};
    end
    assign o_sync = r_sync;
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset/lock supervisor that releases system reset after stable lock
//   ref_clk    12 MHz reference clock
//   rst_n      asynchronous active-low reset
//   pll_locked PLL LOCK, asynchronous to ref_clk
//   pll_resetb PLL RESETB, active low
//   sys_rst_n  system reset, active low
//   ready      high in RUN
//   fail       high once every lock attempt has timed out
//   retry_cnt  timed-out attempts in the current bring-up
//   loss_cnt   saturating lock-loss count, built only with PLL_RESET_SEQUENCER_LOSS_COUNT_EN
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic                  ref_clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    output logic                  pll_resetb,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic                  fail,
    output logic [1:0]            retry_cnt,
    output logic [LOSS_CNT_W-1:0] loss_cnt
);
    localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

    logic             w_locked_s;
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [1:0]       r_retry, w_retry_next;
    logic             r_pll_resetb, r_run, r_fail;

    pll_lock_sync u_lock_sync (
        .i_clk   (ref_clk),
        .i_rst_n (rst_n),
        .i_async (pll_locked),
        .o_sync  (w_locked_s)
    );

    // Lock is tested before the timeout so a lock arriving on the last cycle wins.
    always_comb begin
        w_next       = r_state;
        w_retry_next = r_retry;
        case (r_state)
            S_PLL_RST:   if (r_cnt == RST_LAST) w_next = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (w_locked_s) w_next = S_STABLE;
                else if (r_cnt == TO_LAST) begin
                    if (r_retry == RETRY_MAX) w_next = S_FAIL;
                    else begin
                        w_next       = S_PLL_RST;
                        w_retry_next = r_retry + 2'd1;
                    end
                end
            end
            S_STABLE: begin
                if (!w_locked_s) w_next = S_WAIT_LOCK;
                else if (r_cnt == STABLE_LAST) begin
                    w_next       = S_RUN;
                    w_retry_next = 2'd0;
                end
            end
            S_RUN:   if (!w_locked_s) w_next = S_PLL_RST;
            S_FAIL:  w_next = S_FAIL;
            default: w_next = S_PLL_RST;
        endcase
        // RUN and FAIL never time anything, so the counter idles at zero there.
        w_cnt_next = (w_next != r_state || r_state == S_RUN || r_state == S_FAIL) ? '0 : r_cnt + 1'b1;
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_PLL_RST;
            r_cnt        <= '0;
            r_retry      <= 2'd0;
            r_pll_resetb <= 1'b0;
            r_run        <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_next;
            r_retry      <= w_retry_next;
            r_pll_resetb <= (w_next == S_WAIT_LOCK) || (w_next == S_STABLE) || (w_next == S_RUN);
            r_run        <= (w_next == S_RUN);
            r_fail       <= (w_next == S_FAIL);
        end
    end

`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
    logic                  w_loss_inc;
    logic [LOSS_CNT_W-1:0] r_loss;
    assign w_loss_inc = (r_state == S_RUN) && !w_locked_s;
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n)                          r_loss <= '0;
        else if (w_loss_inc && r_loss != '1) r_loss <= r_loss + 1'b1;
    end
    assign loss_cnt = r_loss;
`else
    assign loss_cnt = '0;
`endif

    assign pll_resetb = r_pll_resetb;
    assign sys_rst_n  = r_run;
    assign ready      = r_run;
    assign fail       = r_fail;
    assign retry_cnt  = r_retry;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed bench with a deadline-based reference model checked every cycle
module tb_pll_reset_sequencer;
    localparam int RST = 4, TO = 20, SC = 8, MAXR = 2, LIM = 3000;
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       ref_clk = 1'b0;
    logic       rst_n, pll_locked;
    logic       pll_resetb, sys_rst_n, ready, fail;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;
    int         checks = 0, failures = 0, n;

    pll_reset_sequencer #(
        .RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(SC), .MAX_RETRIES(MAXR)
    ) dut (
        .ref_clk(ref_clk), .rst_n(rst_n), .pll_locked(pll_locked),
        .pll_resetb(pll_resetb), .sys_rst_n(sys_rst_n), .ready(ready), .fail(fail),
        .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
    );

    always #5 ref_clk = ~ref_clk;

    // Reference model: each phase is given an absolute edge number at which it ends.
    typedef enum {M_HOLD, M_SEEK, M_SETTLE, M_UP, M_DEAD} mphase_t;
    mphase_t m_ph;
    int      m_edge, m_due, m_tries, m_losses;
    logic    m_d1, m_d2;

    always @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= M_HOLD; m_edge <= 1; m_due <= RST; m_tries <= 0; m_losses <= 0;
            m_d1 <= 1'b0; m_d2 <= 1'b0;
        end else begin
            m_edge <= m_edge + 1;
            m_d1   <= pll_locked;
            m_d2   <= m_d1;
            case (m_ph)
                M_HOLD: if (m_edge == m_due) begin m_ph <= M_SEEK; m_due <= m_edge + TO; end
                M_SEEK: begin
                    if (m_d2) begin m_ph <= M_SETTLE; m_due <= m_edge + SC; end
                    else if (m_edge == m_due) begin
                        if (m_tries == MAXR) m_ph <= M_DEAD;
                        else begin m_tries <= m_tries + 1; m_ph <= M_HOLD; m_due <= m_edge + RST; end
                    end
                end
                M_SETTLE: begin
                    if (!m_d2) begin m_ph <= M_SEEK; m_due <= m_edge + TO; end
                    else if (m_edge == m_due) begin m_ph <= M_UP; m_tries <= 0; end
                end
                M_UP: if (!m_d2) begin
                    m_ph <= M_HOLD; m_due <= m_edge + RST;
                    m_losses <= (m_losses < 255) ? m_losses + 1 : 255;
                end
                default: m_ph <= M_DEAD;
            endcase
        end
    end

    function automatic logic [13:0] m_exp();
        return {m_ph inside {M_SEEK, M_SETTLE, M_UP}, m_ph == M_UP, m_ph == M_UP, m_ph == M_DEAD,
                2'(m_tries), LOSS_EN ? 8'(m_losses) : 8'd0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge ref_clk)
        check("cycle_outputs", {pll_resetb, sys_rst_n, ready, fail, retry_cnt, loss_cnt}, m_exp());

    // sel: 0 pll_resetb, 1 sys_rst_n, 2 fail; n = negedges until the signal equals val
    task automatic wait_until(input int sel, input logic val, output int cnt);
        logic s;
        cnt = 0;
        do begin
            @(negedge ref_clk);
            cnt++;
            s = (sel == 0) ? pll_resetb : (sel == 1) ? sys_rst_n : fail;
        end while (s !== val && cnt < LIM);
    endtask

    task automatic do_reset();
        pll_locked = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge ref_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        pll_locked = 1'b0;
        repeat (3) @(negedge ref_clk);
        check("reset_outputs", {pll_resetb, sys_rst_n, ready, fail, retry_cnt, loss_cnt}, 0);
        rst_n = 1'b1;

        // normal bring-up: lock 5 cycles after pll_resetb rises
        wait_until(0, 1'b1, n); check("a_first_rst_low", n, 4);
        repeat (5) @(negedge ref_clk);
        pll_locked = 1'b1;
        wait_until(1, 1'b1, n); check("a_lock_to_run", n, 11);
        check("a_ready", ready, 1);
        check("a_retry", retry_cnt, 0);

        // repeated lock loss in RUN
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            wait_until(1, 1'b0, n); check("d_loss_latency", n, 3);
            if (i == 0) check("d_loss_first", loss_cnt, LOSS_EN ? 1 : 0);
            wait_until(0, 1'b1, n); check("d_rst_low", n, 4);
            pll_locked = 1'b1;
            wait_until(1, 1'b1, n); check("d_relock", n, 11);
        end
        check("d_loss_sat", loss_cnt, LOSS_EN ? 255 : 0);
        check("d_model_losses", m_losses, 255);

        // asynchronous reset while in RUN
        #2 rst_n = 1'b0;
        #1 check("f_async_reset", {pll_resetb, sys_rst_n, ready, fail, retry_cnt, loss_cnt}, 0);
        pll_locked = 1'b0;
        @(negedge ref_clk);
        rst_n = 1'b1;
        wait_until(0, 1'b1, n); check("f_restart_rst_low", n, 4);

        // one-cycle lock drop in STABLE at cnt=5
        pll_locked = 1'b1;
        repeat (6) @(negedge ref_clk);
        pll_locked = 1'b0;
        @(negedge ref_clk);
        pll_locked = 1'b1;
        wait_until(1, 1'b1, n); check("c_stable_restart", n, 11);
        check("c_retry", retry_cnt, 0);

        // lock on the same cycle as the timeout
        do_reset();
        wait_until(0, 1'b1, n); check("e_rst_low", n, 4);
        repeat (17) @(negedge ref_clk);
        pll_locked = 1'b1;
        repeat (3) @(negedge ref_clk);
        check("e_lock_wins_resetb", pll_resetb, 1);
        check("e_lock_wins_retry", retry_cnt, 0);
        wait_until(1, 1'b1, n); check("e_to_run", n, 8);

        // never locks: three attempts then FAIL
        do_reset();
        wait_until(0, 1'b1, n); check("b_rst_low_1", n, 4);
        wait_until(0, 1'b0, n); check("b_timeout_1", n, 20);
        check("b_retry_1", retry_cnt, 1);
        wait_until(0, 1'b1, n); check("b_rst_low_2", n, 4);
        wait_until(0, 1'b0, n); check("b_timeout_2", n, 20);
        check("b_retry_2", retry_cnt, 2);
        wait_until(0, 1'b1, n); check("b_rst_low_3", n, 4);
        wait_until(2, 1'b1, n); check("b_timeout_3", n, 20);
        check("b_fail_resetb", pll_resetb, 0);
        repeat (1000) @(negedge ref_clk);
        check("b_fail_hold", {pll_resetb, sys_rst_n, ready, fail}, 4'b0001);
        check("b_model_dead", m_ph == M_DEAD, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
